// File: rtl/video_softswitch_ctrl.sv
// video_softswitch_ctrl
//   CPU-side decoder for the Apple II video soft switches. It drives the live
//   mode bits to the video generator. Soft-switch reads return the
//   floating-bus byte. IIe-style status reads are also provided.
//
// Ports
//   CLOCK_50            system clock (rising edge)
//   RESET               synchronous reset, active low
//   bus_en/addr/rw      CPU access (bus_en held for several clocks per access)
//   Dl/dl_valid         last video fetch byte, latched as floating-bus data
//   line_start          scanline start pulse (commit point when SYNC_TO_LINE=1)
//   text_mode, mix_mode, hires_mode, page2   live mode outputs
//   dout/dout_oe        read-back data and its bus drive enable
module video_softswitch_ctrl #(
  parameter int          SYNC_TO_LINE = 1,
  parameter logic [15:0] SS_BASE      = 16'hC050,
  parameter logic [15:0] STAT_BASE    = 16'hC01A
) (
  input  logic        CLOCK_50,
  input  logic        RESET,
  input  logic        bus_en,
  input  logic [15:0] addr,
  input  logic        rw,
  input  logic [7:0]  Dl,
  input  logic        dl_valid,
  input  logic        line_start,
  output logic        text_mode,
  output logic        mix_mode,
  output logic        hires_mode,
  output logic        page2,
  output logic [7:0]  dout,
  output logic        dout_oe
);

  // Switch vector bit order matches both addr[2:1] and the status offset:
  // [0]=text [1]=mix [2]=page2 [3]=hires
  localparam logic [3:0] SW_RESET = 4'b0001;

  logic        bus_en_q;
  logic [3:0]  shadow_q, shadow_d;
  logic [3:0]  live_q, live_d;
  logic [7:0]  float_q;
  logic [7:0]  dout_q, dout_d;
  logic        oe_q, oe_d;

  logic        acc, ss_hit, stat_hit;
  logic [15:0] stat_off;

  assign acc      = bus_en & ~bus_en_q;
  assign ss_hit   = acc & (addr[15:3] == SS_BASE[15:3]);
  assign stat_off = addr - STAT_BASE;
  assign stat_hit = acc & (stat_off[15:2] == 14'd0);

  always_comb begin
    shadow_d = shadow_q;
    if (ss_hit) shadow_d[addr[2:1]] = addr[0];
  end

  always_comb begin
    live_d = live_q;
    if (SYNC_TO_LINE != 0) begin
      // Commit includes an access landing on the line_start cycle itself.
      if (line_start) live_d = shadow_d;
    end else begin
      live_d = shadow_q;
    end
  end

  always_comb begin
    oe_d   = oe_q;
    dout_d = dout_q;
    if (rw && (ss_hit || stat_hit)) begin
      oe_d   = 1'b1;
      // The old latch and live values are used here, so a same-cycle fetch or
      // commit does not leak into the returned byte.
      dout_d = ss_hit ? float_q : {live_q[stat_off[1:0]], float_q[6:0]};
    end else if (!bus_en) begin
      oe_d   = 1'b0;
      dout_d = 8'h00;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET) begin
      // Tracking bus_en during reset stops a held access from re-firing on release.
      bus_en_q <= bus_en;
      shadow_q <= SW_RESET;
      live_q   <= SW_RESET;
      float_q  <= 8'h00;
      dout_q   <= 8'h00;
      oe_q     <= 1'b0;
    end else begin
      bus_en_q <= bus_en;
      shadow_q <= shadow_d;
      live_q   <= live_d;
      if (dl_valid) float_q <= Dl;
      dout_q   <= dout_d;
      oe_q     <= oe_d;
    end
  end

  assign text_mode  = live_q[0];
  assign mix_mode   = live_q[1];
  assign page2      = live_q[2];
  assign hires_mode = live_q[3];
  assign dout       = dout_q;
  assign dout_oe    = oe_q;

endmodule

// File: tb/tb_video_softswitch_ctrl.sv
module tb_video_softswitch_ctrl;
  logic        clk = 1'b0;
  logic        rst_n, be, rw;
  logic [15:0] a;
  logic [7:0]  dl;
  logic        dv, ls;

  logic        t0, m0, h0, p0, oe0;
  logic        t1, m1, h1, p1, oe1;
  logic [7:0]  d0, d1;

  always #5 clk = ~clk;

  video_softswitch_ctrl #(.SYNC_TO_LINE(0)) u0 (
    .CLOCK_50(clk), .RESET(rst_n), .bus_en(be), .addr(a), .rw(rw), .Dl(dl),
    .dl_valid(dv), .line_start(ls), .text_mode(t0), .mix_mode(m0),
    .hires_mode(h0), .page2(p0), .dout(d0), .dout_oe(oe0));

  video_softswitch_ctrl #(.SYNC_TO_LINE(1)) u1 (
    .CLOCK_50(clk), .RESET(rst_n), .bus_en(be), .addr(a), .rw(rw), .Dl(dl),
    .dl_valid(dv), .line_start(ls), .text_mode(t1), .mix_mode(m1),
    .hires_mode(h1), .page2(p1), .dout(d1), .dout_oe(oe1));

  int checks = 0;
  int errors = 0;

  // Reference state: switches indexed 0=text 1=mix 2=page2 3=hires
  bit       mon_en = 0;
  bit       m_prev;
  bit [3:0] m_sh, m_l0, m_l1;
  bit [7:0] m_fl, m_do0, m_do1;
  bit       m_oe;
  logic [7:0] rdq0[$], rdq1[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // One bus cycle: drive at negedge, then advance the reference at the posedge.
  task automatic cyc(input bit rst, input bit b, input bit r, input logic [15:0] ad,
                     input bit v, input logic [7:0] d, input bit l);
    bit acc, ss, st, sel;
    bit [3:0] old_sh, old_l0, old_l1;
    bit [7:0] old_fl, v0, v1;
    int n;
    @(negedge clk);
    rst_n = ~rst; be = b; rw = r; a = ad; dv = v; dl = d; ls = l;
    @(posedge clk);
    if (rst) begin
      m_sh = 4'b0001; m_l0 = 4'b0001; m_l1 = 4'b0001;
      m_fl = 0; m_oe = 0; m_do0 = 0; m_do1 = 0; m_prev = b;
      mon_en = 1;
    end else begin
      acc = b && !m_prev;
      m_prev = b;
      ss = acc && ad >= 16'hC050 && ad <= 16'hC057;
      st = acc && ad >= 16'hC01A && ad <= 16'hC01D;
      old_sh = m_sh; old_l0 = m_l0; old_l1 = m_l1; old_fl = m_fl;
      if (ss) begin
        n   = (int'(ad) - 'hC050) / 2;
        sel = ((int'(ad) - 'hC050) % 2) == 1;
        m_sh[n] = sel;
      end
      m_l0 = old_sh;
      if (l) m_l1 = m_sh;
      if (v) m_fl = d;
      if (r && (ss || st)) begin
        if (ss) begin
          v0 = old_fl; v1 = old_fl;
        end else begin
          n  = int'(ad) - 'hC01A;
          v0 = {old_l0[n], old_fl[6:0]};
          v1 = {old_l1[n], old_fl[6:0]};
        end
        m_oe = 1; m_do0 = v0; m_do1 = v1;
        rdq0.push_back(v0); rdq1.push_back(v1);
      end else if (!b) begin
        m_oe = 0; m_do0 = 0; m_do1 = 0;
      end
    end
  endtask

  task automatic access(input logic [15:0] ad, input bit r, input int hold, input int lsat);
    for (int i = 0; i < hold; i++)
      cyc(0, 1, r, ad, 0, 8'h00, i == lsat);
    cyc(0, 0, r, ad, 0, 8'h00, 0);
  endtask

  // Monitor: per-cycle output compare plus read-data pop on each dout_oe rise.
  initial begin
    logic poe0, poe1;
    poe0 = 0; poe1 = 0;
    forever begin
      @(posedge clk); #1;
      if (mon_en) begin
        chk("live0", {4'h0, h0, p0, m0, t0}, {4'h0, m_l0[3], m_l0[2], m_l0[1], m_l0[0]});
        chk("live1", {4'h0, h1, p1, m1, t1}, {4'h0, m_l1[3], m_l1[2], m_l1[1], m_l1[0]});
        chk("oe0", {7'h0, oe0}, {7'h0, m_oe});
        chk("oe1", {7'h0, oe1}, {7'h0, m_oe});
        chk("dout0", d0, m_do0);
        chk("dout1", d1, m_do1);
        if (oe0 === 1'b1 && !poe0) begin
          if (rdq0.size() == 0) chk("rdq0_empty", d0, 8'hxx);
          else chk("rd0", d0, rdq0.pop_front());
        end
        if (oe1 === 1'b1 && !poe1) begin
          if (rdq1.size() == 0) chk("rdq1_empty", d1, 8'hxx);
          else chk("rd1", d1, rdq1.pop_front());
        end
        poe0 = (oe0 === 1'b1); poe1 = (oe1 === 1'b1);
      end
    end
  end

  initial begin
    logic [15:0] addrs [16];
    addrs = '{16'hC050, 16'hC051, 16'hC052, 16'hC053, 16'hC054, 16'hC055,
              16'hC056, 16'hC057, 16'hC01A, 16'hC01B, 16'hC01C, 16'hC01D,
              16'hC058, 16'hC04F, 16'hC019, 16'hC01E};
    rst_n = 0; be = 0; rw = 0; a = 0; dl = 0; dv = 0; ls = 0;
    repeat (3) cyc(1, 0, 0, 16'h0000, 0, 8'h00, 0);
    cyc(0, 0, 0, 16'h0000, 0, 8'h00, 0);
    #2 chk("rst_text", {7'h0, t0}, 8'h01);
    chk("rst_dout", d1, 8'h00);

    access(16'hC050, 0, 4, -1);      // text off
    access(16'hC057, 1, 4, -1);      // hires on, held read
    access(16'hC051, 0, 2, -1);
    access(16'hC050, 1, 2, -1);
    access(16'hC055, 0, 2, -1);
    cyc(0, 0, 0, 16'h0000, 0, 8'h00, 1);  // commit text=0 page2=1 hires=1
    access(16'hC056, 0, 2, 0);       // access coincides with line_start

    cyc(0, 0, 0, 16'h0000, 1, 8'hA5, 0);
    access(16'hC052, 1, 3, -1);
    #2 chk("float_A5_released", d0, 8'h00);
    cyc(0, 0, 0, 16'h0000, 1, 8'hFF, 1);
    cyc(0, 1, 1, 16'hC01B, 0, 8'h00, 0);
    #2 chk("stat_7F", d1, 8'h7F);
    cyc(0, 1, 1, 16'hC01B, 0, 8'h00, 0);
    cyc(0, 0, 0, 16'h0000, 0, 8'h00, 0);

    // Reset in the middle of a held read, then release with bus_en still high
    cyc(0, 1, 1, 16'hC055, 0, 8'h00, 1);
    cyc(0, 1, 1, 16'hC055, 0, 8'h00, 0);
    cyc(1, 1, 1, 16'hC055, 0, 8'h00, 0);
    cyc(1, 1, 1, 16'hC055, 0, 8'h00, 0);
    cyc(0, 1, 1, 16'hC055, 0, 8'h00, 1);
    cyc(0, 1, 1, 16'hC055, 0, 8'h00, 0);
    #2 chk("rst_midacc_page2", {7'h0, p1}, 8'h00);
    cyc(0, 0, 0, 16'h0000, 0, 8'h00, 0);

    for (int k = 0; k < 400; k++) begin
      logic [15:0] ad;
      bit r;
      int hold, gap;
      ad   = addrs[$urandom_range(15)];
      r    = $urandom_range(1);
      hold = $urandom_range(4, 1);
      gap  = $urandom_range(3, 1);
      for (int i = 0; i < hold; i++)
        cyc(0, 1, r, ad, $urandom_range(1), 8'($urandom), $urandom_range(4) == 0);
      for (int i = 0; i < gap; i++)
        cyc($urandom_range(60) == 0, 0, 0, 16'($urandom), $urandom_range(1),
            8'($urandom), $urandom_range(4) == 0);
    end
    repeat (3) cyc(0, 0, 0, 16'h0000, 0, 8'h00, 0);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/video_softswitch_ctrl.md
Name: video_softswitch_ctrl

Overview:
- CPU-side end of the video mode interface. Decodes 6502 bus accesses to the Apple II video soft switches ($C050–$C057) and drives text_mode, mix_mode, hires_mode and page2 into the video generator.
- Returns floating-bus data on soft-switch reads: the last Dl byte the video generator fetched.
- Provides IIe-style status reads ($C01A–$C01D).
- Optionally defers mode changes to the next scanline start so a line is never rendered in mixed modes.

Parameters:
SYNC_TO_LINE, 1, 1: live mode outputs commit on line_start; 0: commit the cycle after the access
SS_BASE, 16'hC050, base address of the 8 soft-switch locations (addr[15:3] match)
STAT_BASE, 16'hC01A, base address of the 4 status locations

Ports:
CLOCK_50  in  1  system clock, all logic on rising edge
RESET  in  1  synchronous reset, active-low (0 = reset)
bus_en  in  1  CPU bus phase active; held high for several clocks per CPU access
addr  in  16  CPU address, stable while bus_en high
rw  in  1  1 = read, 0 = write
Dl  in  8  video fetch data from the video generator's memory path
dl_valid  in  1  Dl holds a freshly fetched byte this cycle
line_start  in  1  one-cycle pulse at the start of each scanline, from the video generator
text_mode  out  1  live TEXT switch
mix_mode  out  1  live MIXED switch
hires_mode  out  1  live HIRES switch
page2  out  1  live PAGE2 switch
dout  out  8  read-back data
dout_oe  out  1  dout drives the CPU data bus

Behaviour:
- Reset: applies on any edge with RESET=0. Sets shadow and live values text=1, mix=0, hires=0, page2=0. Also sets float_latch=0, dout=0, dout_oe=0, clears the access one-shot and any pending commit. Reset mid-access: the access is discarded and is not re-detected when RESET releases unless bus_en deasserts and reasserts first.
- Access strobe: acc = bus_en & ~bus_en_q, where bus_en_q is bus_en registered. Only the first clock of each bus_en assertion is an access.
- Soft-switch decode: acc with addr[15:3]==SS_BASE[15:3]. Reads and writes both act; write data is ignored. The selected switch is addr[2:1], and the new value is addr[0]:
  - 00 = text, cleared by C050, set by C051
  - 01 = mix, C052/C053
  - 10 = page2, C054/C055
  - 11 = hires, C056/C057
- Shadow update: the shadow register updates on the clock edge where acc is seen.
- Commit when SYNC_TO_LINE=0: live outputs equal the shadow, registered, so the change is visible 1 clock after the acc edge.
- Commit when SYNC_TO_LINE=1: on a line_start cycle, live ← shadow_next, where shadow_next includes any access in that same cycle. Between line_starts the live outputs hold. Multiple accesses between line_starts: only the final shadow state is committed.
- Floating bus latch: float_latch ← Dl on each dl_valid cycle.
- Soft-switch read (rw=1, decode hit): on the acc edge, dout ← float_latch value from before any same-cycle dl_valid update, and dout_oe ← 1.
- Status read (acc, rw=1, addr = STAT_BASE+n, n=0..3): dout[7] = live text, mix, page2, hires respectively for n=0,1,2,3. dout[6:0] = float_latch[6:0]. dout_oe ← 1. Status reads do not alter any switch.
- Read hold: dout_oe stays 1 while bus_en stays high and clears the clock after bus_en falls. dout is frozen while dout_oe=1 and returns to 0 when dout_oe clears.
- Writes: never assert dout_oe.
- Non-matching addresses: no effect and dout_oe=0.
- Read-back timing: a status read captures the live value as of the acc cycle. A status read that coincides with a commit returns the pre-commit value.
- Fully synchronous single-clock design: no combinational path from inputs to outputs.

Test Plan:
- Reset held 0 for 3 clocks, then released → text=1, mix=0, hires=0, page2=0, dout_oe=0, dout=8'h00.
- SYNC_TO_LINE=0: write $C050 (bus_en high 4 clocks) → text=0 exactly 1 clock after the acc edge. Then read $C057 → hires=1; no second toggle while bus_en stays high.
- SYNC_TO_LINE=1: accesses $C051, $C050, $C055 with no line_start → outputs unchanged. Then line_start pulse → text=0, page2=1.
- Access to $C056 on the same cycle as line_start (SYNC_TO_LINE=1) → hires=0 committed on that edge.
- dl_valid with Dl=8'hA5, then read $C052 → dout=8'hA5, dout_oe=1 until 1 clock after bus_en falls, then dout=0 and dout_oe=0. Then read $C01B with mix=0 and latch=8'hFF → dout=8'h7F.
- Reset asserted during a held $C055 read → page2=0 and dout_oe=0. After release with bus_en still high, no access and page2 stays 0.
